// File: rtl/hive_reg_lc_bank.sv
// hive_reg_lc_bank
// ----------------
// rbus-mapped register bank for CH lock-in (LC) channels. Each channel has
// a snapshot of its LPF output, a ready flag, an overrun flag and a dither
// left-shift setting.
//
// Address map (relative to BASE):
//   +0       CTRL   write: bit0 = hold, bits[8+n] = W1C ovr[n]
//                   read : bit0 = hold, bits[8+n] = ovr[n], bits[16+n] = rdy[n]
//   +1+2n    DSHL[n] dither shift, D_SHL_W bits, zero-extended on read
//   +2+2n    DATA[n] snapshot; reading it clears rdy[n]
// Any other address is ignored and reads as zero.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   rbus_addr_i        rbus address (ADDR_W)
//   rbus_wr_i          write strobe
//   rbus_rd_i          read strobe
//   rbus_wr_data_i     write data (DATA_W)
//   rbus_rd_data_o     read data, registered, valid 1 cycle after the read,
//                      zero otherwise
//   lpf_i              CH packed LPF samples, channel n at [n*DATA_W +: DATA_W]
//   ltch_i             one-cycle snapshot strobe for all channels
//   d_shl_o            CH packed dither shifts, channel n at [n*D_SHL_W +: D_SHL_W]
//   rdy_o              registered OR of all ready flags
module hive_reg_lc_bank #(
  parameter int                   CH        = 2,
  parameter int                   DATA_W    = 32,
  parameter int                   ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]    BASE      = 8'h40,
  parameter int                   D_SHL_W   = 5,
  parameter logic [D_SHL_W-1:0]   D_SHL_RST = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_W-1:0]       rbus_addr_i,
  input  logic                    rbus_wr_i,
  input  logic                    rbus_rd_i,
  input  logic [DATA_W-1:0]       rbus_wr_data_i,
  output logic [DATA_W-1:0]       rbus_rd_data_o,
  input  logic [CH*DATA_W-1:0]    lpf_i,
  input  logic                    ltch_i,
  output logic [CH*D_SHL_W-1:0]   d_shl_o,
  output logic                    rdy_o
);

  logic                   r_hold;
  logic [DATA_W-1:0]      r_rd_data;
  logic                   r_rdy_o;

  logic                   w_cap;
  logic                   w_ctrl_wr;
  logic [CH-1:0]          w_rdy;
  logic [CH-1:0]          w_rdy_nxt;
  logic [CH-1:0]          w_ovr;
  logic [CH*DATA_W-1:0]   w_snap;
  logic [CH*D_SHL_W-1:0]  w_dshl;
  logic [DATA_W-1:0]      w_ctrl;
  logic [DATA_W-1:0]      w_rd_val;
  logic                   w_rd_dec;

  // Only a few write-data bits are meaningful; the rest are deliberately dropped.
  logic                   w_unused_wdata;
  assign w_unused_wdata = &{1'b0, rbus_wr_data_i};

  // A capture happens on every strobe unless software has frozen the bank.
  assign w_cap     = ltch_i && !r_hold;
  assign w_ctrl_wr = rbus_wr_i && (rbus_addr_i == BASE);

  // ---------------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    localparam logic [ADDR_W-1:0] A_DSHL = ADDR_W'(BASE + 1 + 2*gi);
    localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(BASE + 2 + 2*gi);

    logic                w_dshl_wr;
    logic                w_data_rd;
    logic                w_ovr_set;
    logic                w_ovr_clr;
    logic [DATA_W-1:0]   r_snap;
    logic                r_rdy;
    logic                r_ovr;
    logic [D_SHL_W-1:0]  r_dshl;

    assign w_dshl_wr = rbus_wr_i && (rbus_addr_i == A_DSHL);
    assign w_data_rd = rbus_rd_i && (rbus_addr_i == A_DATA);

    // Overrun only when an unread sample is overwritten; a read in the same
    // cycle consumes the old sample, so it is not lost.
    assign w_ovr_set = w_cap && r_rdy && !w_data_rd;
    assign w_ovr_clr = w_ctrl_wr && rbus_wr_data_i[8+gi];

    // Capture wins over a concurrent read: the new sample is still unread.
    assign w_rdy_nxt[gi] = w_cap ? 1'b1 : (w_data_rd ? 1'b0 : r_rdy);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_snap <= '0;
        r_rdy  <= 1'b0;
        r_ovr  <= 1'b0;
        r_dshl <= D_SHL_RST;
      end else begin
        if (w_cap) begin
          r_snap <= lpf_i[gi*DATA_W +: DATA_W];
        end
        r_rdy <= w_rdy_nxt[gi];
        // Set has priority over the software clear.
        if (w_ovr_set) begin
          r_ovr <= 1'b1;
        end else if (w_ovr_clr) begin
          r_ovr <= 1'b0;
        end
        if (w_dshl_wr) begin
          r_dshl <= rbus_wr_data_i[D_SHL_W-1:0];
        end
      end
    end

    assign w_rdy[gi]                        = r_rdy;
    assign w_ovr[gi]                        = r_ovr;
    assign w_snap[gi*DATA_W +: DATA_W]      = r_snap;
    assign w_dshl[gi*D_SHL_W +: D_SHL_W]    = r_dshl;
  end

  // ---------------------------------------------------------------------------
  // Read path (uses pre-write state, so write+read to one address returns the
  // old value)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ctrl    = '0;
    w_ctrl[0] = r_hold;
    for (int i = 0; i < CH; i++) begin
      w_ctrl[8+i]  = w_ovr[i];
      w_ctrl[16+i] = w_rdy[i];
    end
  end

  always_comb begin
    w_rd_val = '0;
    w_rd_dec = 1'b0;
    if (rbus_addr_i == BASE) begin
      w_rd_val = w_ctrl;
      w_rd_dec = 1'b1;
    end
    for (int i = 0; i < CH; i++) begin
      if (rbus_addr_i == ADDR_W'(BASE + 1 + 2*i)) begin
        w_rd_val                = '0;
        w_rd_val[D_SHL_W-1:0]   = w_dshl[i*D_SHL_W +: D_SHL_W];
        w_rd_dec                = 1'b1;
      end
      if (rbus_addr_i == ADDR_W'(BASE + 2 + 2*i)) begin
        w_rd_val = w_snap[i*DATA_W +: DATA_W];
        w_rd_dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold    <= 1'b0;
      r_rd_data <= '0;
      r_rdy_o   <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_hold <= rbus_wr_data_i[0];
      end
      r_rd_data <= (rbus_rd_i && w_rd_dec) ? w_rd_val : '0;
      // Track the next-state flags so rdy_o changes on the same edge as rdy[n].
      r_rdy_o   <= |w_rdy_nxt;
    end
  end

  assign rbus_rd_data_o = r_rd_data;
  assign d_shl_o        = w_dshl;
  assign rdy_o          = r_rdy_o;

endmodule

// File: tb/tb_hive_reg_lc_bank.sv
// Self-checking bench for hive_reg_lc_bank (CH=2, DATA_W=32, BASE=8'h40).
// Directed register scenarios followed by random rbus/ltch traffic, all
// compared against a transaction-level model of the register bank.
module tb_hive_reg_lc_bank;

  localparam int          CH   = 2;
  localparam int          DW   = 32;
  localparam int          AW   = 8;
  localparam int          SW   = 5;
  localparam logic [7:0]  BASE = 8'h40;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [AW-1:0]     rbus_addr_i = '0;
  logic              rbus_wr_i = 1'b0;
  logic              rbus_rd_i = 1'b0;
  logic [DW-1:0]     rbus_wr_data_i = '0;
  logic [DW-1:0]     rbus_rd_data_o;
  logic [CH*DW-1:0]  lpf_i = '0;
  logic              ltch_i = 1'b0;
  logic [CH*SW-1:0]  d_shl_o;
  logic              rdy_o;

  hive_reg_lc_bank #(
    .CH(CH), .DATA_W(DW), .ADDR_W(AW), .BASE(BASE), .D_SHL_W(SW), .D_SHL_RST(5'd0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rbus_addr_i(rbus_addr_i), .rbus_wr_i(rbus_wr_i), .rbus_rd_i(rbus_rd_i),
    .rbus_wr_data_i(rbus_wr_data_i), .rbus_rd_data_o(rbus_rd_data_o),
    .lpf_i(lpf_i), .ltch_i(ltch_i), .d_shl_o(d_shl_o), .rdy_o(rdy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: register contents as software sees them.
  logic [31:0] m_snap [CH];
  bit          m_rdy  [CH];
  bit          m_ovr  [CH];
  bit          m_hold;
  logic [4:0]  m_dshl [CH];
  logic [31:0] m_exp_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < CH; n++) begin
      m_snap[n] = '0; m_rdy[n] = 0; m_ovr[n] = 0; m_dshl[n] = '0;
    end
    m_hold   = 0;
    m_exp_rd = '0;
  endtask

  function automatic logic [31:0] model_ctrl();
    logic [31:0] v = '0;
    v[0] = m_hold;
    for (int n = 0; n < CH; n++) begin
      v[8+n]  = m_ovr[n];
      v[16+n] = m_rdy[n];
    end
    return v;
  endfunction

  function automatic logic [31:0] model_dshl_flat();
    logic [31:0] v = '0;
    for (int n = 0; n < CH; n++) v[n*SW +: SW] = m_dshl[n];
    return v;
  endfunction

  function automatic bit model_any_rdy();
    bit r = 0;
    for (int n = 0; n < CH; n++) r |= m_rdy[n];
    return r;
  endfunction

  // Apply one cycle of bus/strobe activity, advance the model, then check
  // the registered outputs 1 time unit after the edge.
  task automatic step(input logic [7:0] a, input bit wr, input bit rd,
                      input logic [31:0] wd, input bit lt, input logic [63:0] lpf,
                      input string tag);
    int  off;
    bit  cap;
    bit  data_rd;
    rbus_addr_i    = a;
    rbus_wr_i      = wr;
    rbus_rd_i      = rd;
    rbus_wr_data_i = wd;
    ltch_i         = lt;
    lpf_i          = lpf;
    off            = int'(a) - int'(BASE);
    if (rst_i) begin
      model_reset();
    end else begin
      // Read observes the state before this cycle's updates.
      m_exp_rd = '0;
      if (rd) begin
        if (off == 0)                                   m_exp_rd = model_ctrl();
        else if (off >= 1 && off <= 2*CH && off % 2 == 1) m_exp_rd = 32'(m_dshl[(off-1)/2]);
        else if (off >= 2 && off <= 2*CH && off % 2 == 0) m_exp_rd = m_snap[(off-2)/2];
      end
      cap = lt && !m_hold;
      for (int n = 0; n < CH; n++) begin
        data_rd = rd && (off == 2 + 2*n);
        if (cap && m_rdy[n] && !data_rd) m_ovr[n] = 1;
        else if (wr && off == 0 && wd[8+n]) m_ovr[n] = 0;
        if (cap) begin
          m_rdy[n]  = 1;
          m_snap[n] = lpf[n*32 +: 32];
        end else if (data_rd) begin
          m_rdy[n] = 0;
        end
        if (wr && off == 1 + 2*n) m_dshl[n] = wd[4:0];
      end
      if (wr && off == 0) m_hold = wd[0];
    end
    @(posedge clk_i);
    #1;
    $display("txn %-8s a=%02h wr=%0d rd=%0d wd=%08h lt=%0d -> rd_data=%08h dshl=%03h rdy=%0d",
             tag, a, wr, rd, wd, lt, rbus_rd_data_o, d_shl_o, rdy_o);
    check({tag, ".rd"},   rbus_rd_data_o,  m_exp_rd);
    check({tag, ".dshl"}, 32'(d_shl_o),    model_dshl_flat());
    check({tag, ".rdy"},  32'(rdy_o),      32'(model_any_rdy()));
  endtask

  task automatic rd(input logic [7:0] a, input string tag);
    step(a, 0, 1, 32'h0, 0, lpf_i, tag);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string tag);
    step(a, 1, 0, d, 0, lpf_i, tag);
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.rd",   rbus_rd_data_o, 32'h0);
    check("rst.dshl", 32'(d_shl_o),   32'h0);
    check("rst.rdy",  32'(rdy_o),     32'h0);
    rst_i = 1'b0;

    // Dither shift write/read, upper write bits dropped
    wr(BASE+3, 32'hFFFF_FF13, "dshl1_wr");
    check("s39.dshl1", 32'(d_shl_o[9:5]), 32'h13);
    rd(BASE+3, "dshl1_rd");
    check("s39.rd", rbus_rd_data_o, 32'h13);

    // Single capture, read back, rdy lifecycle
    step(BASE+6, 0, 0, 0, 1, {32'hA5A5_0001, 32'h1234_5678}, "cap1");
    check("s40.rdy_o1", 32'(rdy_o), 32'h1);
    rd(BASE, "ctrl_a");
    check("s40.ctrl_a", rbus_rd_data_o, 32'h0003_0000);
    rd(BASE+2, "data0");
    check("s40.data0", rbus_rd_data_o, 32'h1234_5678);
    rd(BASE+4, "data1");
    rd(BASE, "ctrl_b");
    check("s40.ctrl_b", rbus_rd_data_o, 32'h0);
    check("s40.rdy_o0", 32'(rdy_o), 32'h0);

    // Overrun and W1C
    step(BASE+6, 0, 0, 0, 1, 64'h1111_1111_2222_2222, "cap2");
    step(BASE+6, 0, 0, 0, 1, 64'h3333_3333_4444_4444, "cap3");
    rd(BASE, "ctrl_ovr");
    check("s41.ovr", rbus_rd_data_o, 32'h0003_0300);
    wr(BASE, 32'h100, "w1c0");
    rd(BASE, "ctrl_w1c");
    check("s41.w1c", rbus_rd_data_o, 32'h0003_0200);

    // Clean up, then read DATA0 together with a capture
    rd(BASE+2, "clr0");
    rd(BASE+4, "clr1");
    wr(BASE, 32'h300, "w1c_all");
    step(BASE+6, 0, 0, 0, 1, 64'h0000_00B1_0000_00A0, "capA");
    step(BASE+2, 0, 1, 0, 1, 64'h0000_00B2_0000_00B0, "rdcap");
    check("s42.old", rbus_rd_data_o, 32'h0000_00A0);
    rd(BASE, "ctrl_rc");
    check("s42.ctrl", rbus_rd_data_o, 32'h0003_0200);

    // Hold freezes snapshots
    rd(BASE+2, "clr0b");
    rd(BASE+4, "clr1b");
    wr(BASE, 32'h301, "hold_on");
    step(BASE+6, 0, 0, 0, 1, 64'hDEAD_BEEF_FEED_F00D, "cap_hold");
    rd(BASE, "ctrl_hold");
    check("s43.ctrl", rbus_rd_data_o, 32'h0000_0001);
    rd(BASE+2, "data0_h");
    check("s43.snap", rbus_rd_data_o, 32'h0000_00B0);
    rd(BASE+9, "unmapped");
    check("s43.unmap", rbus_rd_data_o, 32'h0);
    wr(BASE, 32'h0, "hold_off");

    // Simultaneous write+read of DSHL0: old value returned, write lands
    wr(BASE+1, 32'h7, "dshl0_a");
    step(BASE+1, 1, 1, 32'h1A, 0, lpf_i, "dshl0_wr");
    check("s32.old", rbus_rd_data_o, 32'h7);

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      logic [7:0]  a;
      logic [31:0] d;
      int          k;
      k = $urandom_range(0, 9);
      a = (k < 8) ? BASE + 8'(k) : 8'($urandom);
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d[0] = 1'b0;
      step(a, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, d,
           $urandom_range(0, 3) == 0, {$urandom, $urandom}, "rnd");
    end

    // Asynchronous reset mid-read after a capture
    wr(BASE, 32'h0, "unhold");
    wr(BASE+3, 32'h0F, "dshl1_b");
    step(BASE+6, 0, 0, 0, 1, 64'h5555_0002_CAFE_0001, "cap_r");
    rd(BASE+2, "rd_r");
    check("s44.pre", rbus_rd_data_o, 32'hCAFE_0001);
    rbus_rd_i   = 1'b1;
    rbus_addr_i = BASE + 4;
    #2 rst_i = 1'b1;
    #1;
    check("s44.rd",   rbus_rd_data_o, 32'h0);
    check("s44.rdy",  32'(rdy_o),     32'h0);
    check("s44.dshl", 32'(d_shl_o),   32'h0);
    model_reset();
    step(BASE+2, 1, 1, 32'hFFFF_FFFF, 1, 64'h1, "in_rst");
    rst_i = 1'b0;
    rd(BASE, "post_rst");
    rd(BASE+2, "post_rst2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
